// File: rtl/global_pkg.sv
// rtl/global_pkg.sv - shared decode types, opcodes and select encodings for the control unit
package global_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef struct packed {
    logic [6:0] funct7;
    logic [6:0] opcode;
  } decode_t;

  typedef enum logic [1:0] {I_IMM_SRC, REG_SRC} sr2_src_t;

  typedef enum logic [2:0] {
    ALU_INPUT, U_IMM_SRC, AUIPC_SRC, PC_SRC, LOAD_SRC, MULDIV_SRC
  } regfile_src_t;

  typedef enum logic [1:0] {J_IMM, I_IMM, B_IMM} jmp_target_src_t;

  typedef enum logic [1:0] {MEM_NONE, LOAD_DATA, STORE_DATA} memory_operation_t;

  typedef enum logic [1:0] {IDLE, MEM, MULDIV, FAULT} cu_state_t;

endpackage

// File: rtl/cu_timeout_counter.sv
// rtl/cu_timeout_counter.sv - bus-cycle watchdog; expired on the last allowed wait cycle
module cu_timeout_counter #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TMO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/control_unit_mc.sv
// rtl/control_unit_mc.sv - multi-cycle instruction control unit with bus-fault and muldiv sequencing
module control_unit_mc
  import global_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = $clog2(MEM_TIMEOUT + 1),
  parameter int ENABLE_M    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              execute,
  input  decode_t           decode_bus,
  output logic              busy,
  output logic              done,
  output sr2_src_t          sr2_src,
  output regfile_src_t      regfile_src,
  output jmp_target_src_t   jmp_target_src,
  output logic              regfile_wr,
  output logic              jump,
  output logic              enable_branch,
  output memory_operation_t memory_operation,
  output logic              cyc,
  input  logic              ack,
  input  logic              err,
  output logic              muldiv_start,
  input  logic              muldiv_done,
  output logic              illegal_instr,
  output logic              bus_fault
);

  cu_state_t  state;
  logic [6:0] op_q;
  logic [6:0] opc;
  logic       m_enc;
  logic       tmo_expired;
  logic       mem_fault;

  // Selects follow the live decode while idle and the latched opcode otherwise.
  assign opc       = (state == IDLE) ? decode_bus.opcode : op_q;
  assign m_enc     = (decode_bus.opcode == OP) && (decode_bus.funct7 == MULDIV_FUNCT7);
  assign mem_fault = err || (!ack && tmo_expired);

  cu_timeout_counter #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMO_W      (TMO_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != MEM),
    .enable ((state == MEM) && !ack && !err),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (execute) begin
            op_q <= decode_bus.opcode;
            if (decode_bus.opcode == LOAD || decode_bus.opcode == STORE) begin
              state <= MEM;
            end else if (m_enc && ENABLE_M != 0) begin
              state <= MULDIV;
            end
          end
        end
        MEM: begin
          if (mem_fault) begin
            state <= FAULT;
          end else if (ack) begin
            state <= IDLE;
          end
        end
        MULDIV: if (muldiv_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    sr2_src          = I_IMM_SRC;
    regfile_src      = ALU_INPUT;
    jmp_target_src   = J_IMM;
    regfile_wr       = 1'b0;
    jump             = 1'b0;
    enable_branch    = 1'b0;
    memory_operation = MEM_NONE;
    cyc              = 1'b0;
    muldiv_start     = 1'b0;
    illegal_instr    = 1'b0;
    bus_fault        = 1'b0;
    if (!rst && (state != IDLE || execute)) begin
      case (opc)
        OP:     sr2_src = REG_SRC;
        LUI:    regfile_src = U_IMM_SRC;
        AUIPC:  regfile_src = AUIPC_SRC;
        JAL:    regfile_src = PC_SRC;
        JALR: begin
          regfile_src    = PC_SRC;
          jmp_target_src = I_IMM;
        end
        BRANCH: jmp_target_src = B_IMM;
        LOAD:   regfile_src = LOAD_SRC;
        default: ;
      endcase
      case (state)
        IDLE: begin
          case (opc)
            OP_IMM, LUI, AUIPC: begin
              regfile_wr = 1'b1;
              done       = 1'b1;
            end
            OP: begin
              if (!m_enc) begin
                regfile_wr = 1'b1;
                done       = 1'b1;
              end else if (ENABLE_M != 0) begin
                muldiv_start = 1'b1;
                busy         = 1'b1;
              end else begin
                illegal_instr = 1'b1;
                done          = 1'b1;
              end
            end
            JAL, JALR: begin
              regfile_wr = 1'b1;
              jump       = 1'b1;
              done       = 1'b1;
            end
            BRANCH: begin
              enable_branch = 1'b1;
              done          = 1'b1;
            end
            LOAD, STORE: busy = 1'b1;
            default: begin
              illegal_instr = 1'b1;
              done          = 1'b1;
            end
          endcase
        end
        MEM: begin
          busy             = 1'b1;
          cyc              = 1'b1;
          memory_operation = (op_q == LOAD) ? LOAD_DATA : STORE_DATA;
          if (!mem_fault && ack) begin
            done       = 1'b1;
            regfile_wr = (op_q == LOAD);
          end
        end
        MULDIV: begin
          busy        = 1'b1;
          regfile_src = MULDIV_SRC;
          if (muldiv_done) begin
            regfile_wr = 1'b1;
            done       = 1'b1;
          end
        end
        default: begin
          busy      = 1'b1;
          done      = 1'b1;
          bus_fault = 1'b1;
        end
      endcase
    end
  end

endmodule
